// File: rtl/quant_mac_cell.sv
// Quantized multiply-accumulate cell for a chained dot-product array with a shared result bus.
// Build with QMAC_SATURATE_EN defined to clamp results; otherwise results wrap to RESULT_WIDTH bits.
module quant_mac_cell #(
  parameter int DATA_WIDTH    = 8,
  parameter int RESULT_WIDTH  = 16,
  parameter int ACC_WIDTH     = 24,
  parameter int WEIGHT_AMOUNT = 4,
  parameter int INDEX_WIDTH   = 10,
  parameter int INPUT_OFFSET  = 0,
  parameter int WEIGHT_OFFSET = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INDEX_WIDTH-1:0]  input_index,
  input  logic [DATA_WIDTH-1:0]   input_value,
  input  logic                    input_enable,
  input  logic [RESULT_WIDTH:0]   input_result,
  output logic [INDEX_WIDTH-1:0]  output_index,
  output logic [DATA_WIDTH-1:0]   output_value,
  output logic                    output_enable,
  output logic [RESULT_WIDTH:0]   output_result,
  input  logic                    weight_load_en,
  input  logic [INDEX_WIDTH-1:0]  weight_load_addr,
  input  logic [DATA_WIDTH-1:0]   weight_load_data,
  output logic                    overflow_err,
  output logic                    busy
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH + 2;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(WEIGHT_AMOUNT - 1);
  localparam logic signed [DATA_WIDTH:0] IN_OFF = (DATA_WIDTH + 1)'(INPUT_OFFSET);
  localparam logic signed [DATA_WIDTH:0] W_OFF  = (DATA_WIDTH + 1)'(WEIGHT_OFFSET);

  logic [DATA_WIDTH-1:0]         weights [WEIGHT_AMOUNT];
  logic [DATA_WIDTH-1:0]         w_sel;
  logic signed [DATA_WIDTH:0]    a_op;
  logic signed [DATA_WIDTH:0]    w_op;
  logic signed [PROD_WIDTH-1:0]  prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [ACC_WIDTH-1:0]   acc_base;
  logic signed [ACC_WIDTH-1:0]   acc_sum;
  logic                          in_range;
  logic                          is_first;
  logic                          is_last;
  logic                          local_done;
  logic                          up_valid;
  logic [RESULT_WIDTH-1:0]       local_res;
  logic [RESULT_WIDTH-1:0]       pending;

  // Weight is read from the current registers, so a same-cycle load only affects later vectors.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < WEIGHT_AMOUNT; i++) begin
      if (input_index == INDEX_WIDTH'(i)) w_sel = weights[i];
    end
  end

  always_comb begin
    a_op       = $signed({1'b0, input_value}) - IN_OFF;
    w_op       = $signed({1'b0, w_sel}) - W_OFF;
    prod       = PROD_WIDTH'(a_op) * PROD_WIDTH'(w_op);
    prod_ext   = ACC_WIDTH'(prod);
    in_range   = input_index <= LAST_IDX;
    is_first   = input_index == '0;
    is_last    = input_index == LAST_IDX;
    acc_base   = is_first ? '0 : acc;
    acc_sum    = acc_base + prod_ext;
    local_done = input_enable && is_last;
    up_valid   = input_result[RESULT_WIDTH];
  end

`ifdef QMAC_SATURATE_EN
  logic [ACC_WIDTH-RESULT_WIDTH:0] upper;
  logic                            fits;

  // The value fits when every bit above the result sign bit matches it.
  always_comb begin
    upper = acc_sum[ACC_WIDTH-1:RESULT_WIDTH-1];
    fits  = (&upper) | (~|upper);
    if (fits)
      local_res = acc_sum[RESULT_WIDTH-1:0];
    else if (acc_sum[ACC_WIDTH-1])
      local_res = {1'b1, {(RESULT_WIDTH-1){1'b0}}};
    else
      local_res = {1'b0, {(RESULT_WIDTH-1){1'b1}}};
  end
`else
  always_comb begin
    local_res = acc_sum[RESULT_WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WEIGHT_AMOUNT; i++) weights[i] <= '0;
    end else if (weight_load_en) begin
      for (int i = 0; i < WEIGHT_AMOUNT; i++) begin
        if (weight_load_addr == INDEX_WIDTH'(i)) weights[i] <= weight_load_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (input_enable && in_range) begin
      acc <= is_last ? '0 : acc_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_index  <= '0;
      output_value  <= '0;
      output_enable <= 1'b0;
    end else begin
      output_index  <= input_enable ? input_index : '0;
      output_value  <= input_enable ? input_value : '0;
      output_enable <= input_enable;
    end
  end

  // Upstream wins the bus; a local result waits in the single pending slot or is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_result <= '0;
      pending       <= '0;
      busy          <= 1'b0;
      overflow_err  <= 1'b0;
    end else if (up_valid) begin
      output_result <= input_result;
      if (local_done) begin
        if (busy) begin
          overflow_err <= 1'b1;
        end else begin
          pending <= local_res;
          busy    <= 1'b1;
        end
      end
    end else if (busy) begin
      output_result <= {1'b1, pending};
      if (local_done) begin
        pending <= local_res;
      end else begin
        busy <= 1'b0;
      end
    end else if (local_done) begin
      output_result <= {1'b1, local_res};
    end else begin
      output_result <= '0;
    end
  end

endmodule

// File: tb/tb_quant_mac_cell.sv
// Directed testbench for quant_mac_cell: a default-width cell plus an 8-bit-result cell for narrowing.
module tb_quant_mac_cell;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  input_index = '0;
  logic [7:0]  input_value = '0;
  logic        input_enable = 1'b0;
  logic [16:0] input_result = '0;
  logic [8:0]  input_result8 = '0;
  logic        weight_load_en = 1'b0;
  logic [9:0]  weight_load_addr = '0;
  logic [7:0]  weight_load_data = '0;

  logic [9:0]  output_index;
  logic [7:0]  output_value;
  logic        output_enable;
  logic [16:0] output_result;
  logic        overflow_err;
  logic        busy;

  logic [9:0]  output_index8;
  logic [7:0]  output_value8;
  logic        output_enable8;
  logic [8:0]  output_result8;
  logic        overflow_err8;
  logic        busy8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  quant_mac_cell u_dut (
    .clk(clk), .rst(rst),
    .input_index(input_index), .input_value(input_value), .input_enable(input_enable),
    .input_result(input_result),
    .output_index(output_index), .output_value(output_value), .output_enable(output_enable),
    .output_result(output_result),
    .weight_load_en(weight_load_en), .weight_load_addr(weight_load_addr),
    .weight_load_data(weight_load_data),
    .overflow_err(overflow_err), .busy(busy)
  );

  quant_mac_cell #(.RESULT_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .input_index(input_index), .input_value(input_value), .input_enable(input_enable),
    .input_result(input_result8),
    .output_index(output_index8), .output_value(output_value8), .output_enable(output_enable8),
    .output_result(output_result8),
    .weight_load_en(weight_load_en), .weight_load_addr(weight_load_addr),
    .weight_load_data(weight_load_data),
    .overflow_err(overflow_err8), .busy(busy8)
  );

  function automatic logic [31:0] vres(input logic [15:0] v);
    return 32'h10000 | 32'(v);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [9:0] idx, input logic [7:0] val,
                               input logic [16:0] res, input logic we,
                               input logic [9:0] wa, input logic [7:0] wd);
    input_enable     = en;
    input_index      = idx;
    input_value      = val;
    input_result     = res;
    weight_load_en   = we;
    weight_load_addr = wa;
    weight_load_data = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic feed(input logic [9:0] idx, input logic [7:0] val, input logic [16:0] res);
    applyStimulus(1'b1, idx, val, res, 1'b0, '0, '0);
  endtask

  task automatic loadWeight(input logic [9:0] addr, input logic [7:0] data);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, addr, data);
  endtask

  task automatic loadDefault();
    loadWeight(10'd0, 8'd1);
    loadWeight(10'd1, 8'd2);
    loadWeight(10'd2, 8'd3);
    loadWeight(10'd3, 8'd4);
  endtask

  initial begin
    #2;
    checkOutput("rst_result", 32'(output_result), 32'd0);
    checkOutput("rst_enable", 32'(output_enable), 32'd0);
    checkOutput("rst_flags", {30'd0, busy, overflow_err}, 32'd0);
    checkOutput("rst_dut8", {2'd0, output_index8, output_value8, output_enable8, output_result8,
                             busy8, overflow_err8}, 32'd0);
    rst = 1'b0;

    loadDefault();
    loadWeight(10'd4, 8'd50);
    feed(10'd0, 8'd1, '0);
    checkOutput("fwd_enable", 32'(output_enable), 32'd1);
    checkOutput("fwd_index", 32'(output_index), 32'd0);
    checkOutput("fwd_value", 32'(output_value), 32'd1);
    checkOutput("mid_result", 32'(output_result), 32'd0);
    feed(10'd1, 8'd1, '0);
    feed(10'd2, 8'd1, '0);
    feed(10'd3, 8'd1, '0);
    checkOutput("dot_1111", 32'(output_result), vres(16'd10));
    idle();
    checkOutput("idle_result", 32'(output_result), 32'd0);
    checkOutput("idle_enable", 32'(output_enable), 32'd0);

    feed(10'd0, 8'd2, '0);
    feed(10'd1, 8'd3, '0);
    feed(10'd2, 8'd0, '0);
    feed(10'd3, 8'd5, '0);
    checkOutput("dot_2305", 32'(output_result), vres(16'd28));

    feed(10'd9, 8'd77, '0);
    checkOutput("oor_fwd_index", 32'(output_index), 32'd9);
    checkOutput("oor_no_result", 32'(output_result), 32'd0);

    feed(10'd0, 8'd1, '0);
    feed(10'd1, 8'd1, '0);
    feed(10'd2, 8'd1, '0);
    feed(10'd3, 8'd1, 17'h10000 | 17'd55);
    checkOutput("coll_upstream", 32'(output_result), vres(16'd55));
    checkOutput("coll_busy", 32'(busy), 32'd1);
    idle();
    checkOutput("coll_pending", 32'(output_result), vres(16'd10));
    checkOutput("coll_busy_clr", 32'(busy), 32'd0);
    idle();
    checkOutput("coll_empty", 32'(output_result), 32'd0);

    feed(10'd0, 8'd1, '0);
    feed(10'd1, 8'd1, '0);
    feed(10'd2, 8'd1, '0);
    feed(10'd3, 8'd1, 17'h10000 | 17'd7);
    feed(10'd0, 8'd2, 17'h10000 | 17'd7);
    feed(10'd1, 8'd2, 17'h10000 | 17'd7);
    feed(10'd2, 8'd2, 17'h10000 | 17'd7);
    checkOutput("repl_hold_busy", 32'(busy), 32'd1);
    feed(10'd3, 8'd2, '0);
    checkOutput("repl_old_out", 32'(output_result), vres(16'd10));
    checkOutput("repl_busy", 32'(busy), 32'd1);
    idle();
    checkOutput("repl_new_out", 32'(output_result), vres(16'd20));
    checkOutput("repl_busy_clr", 32'(busy), 32'd0);
    checkOutput("repl_no_ovf", 32'(overflow_err), 32'd0);

    feed(10'd0, 8'd1, '0);
    feed(10'd1, 8'd1, '0);
    feed(10'd2, 8'd1, '0);
    feed(10'd3, 8'd1, 17'h10000 | 17'd7);
    feed(10'd0, 8'd2, 17'h10000 | 17'd7);
    feed(10'd1, 8'd2, 17'h10000 | 17'd7);
    feed(10'd2, 8'd2, 17'h10000 | 17'd7);
    feed(10'd3, 8'd2, 17'h10000 | 17'd7);
    checkOutput("ovf_upstream", 32'(output_result), vres(16'd7));
    checkOutput("ovf_set", 32'(overflow_err), 32'd1);
    idle();
    checkOutput("ovf_kept_first", 32'(output_result), vres(16'd10));
    checkOutput("ovf_busy_clr", 32'(busy), 32'd0);
    idle();
    checkOutput("ovf_dropped", 32'(output_result), 32'd0);
    checkOutput("ovf_sticky", 32'(overflow_err), 32'd1);

    feed(10'd0, 8'd1, '0);
    feed(10'd1, 8'd1, '0);
    applyStimulus(1'b1, 10'd2, 8'd1, '0, 1'b1, 10'd2, 8'd10);
    feed(10'd3, 8'd1, '0);
    checkOutput("same_cyc_old_w", 32'(output_result), vres(16'd10));
    feed(10'd0, 8'd1, '0);
    feed(10'd1, 8'd1, '0);
    feed(10'd2, 8'd1, '0);
    feed(10'd3, 8'd1, '0);
    checkOutput("same_cyc_new_w", 32'(output_result), vres(16'd17));

    feed(10'd0, 8'd1, '0);
    feed(10'd1, 8'd1, '0);
    rst = 1'b1;
    #2;
    checkOutput("mrst_enable", 32'(output_enable), 32'd0);
    checkOutput("mrst_index", 32'(output_index), 32'd0);
    checkOutput("mrst_value", 32'(output_value), 32'd0);
    checkOutput("mrst_flags", {30'd0, busy, overflow_err}, 32'd0);
    rst = 1'b0;
    feed(10'd0, 8'd5, '0);
    feed(10'd1, 8'd5, '0);
    feed(10'd2, 8'd5, '0);
    feed(10'd3, 8'd5, '0);
    checkOutput("mrst_zero_w", 32'(output_result), vres(16'd0));
    loadDefault();
    feed(10'd0, 8'd1, '0);
    feed(10'd1, 8'd1, '0);
    feed(10'd2, 8'd1, '0);
    feed(10'd3, 8'd1, '0);
    checkOutput("mrst_recover", 32'(output_result), vres(16'd10));

    for (int i = 0; i < 4; i++) loadWeight(10'(i), 8'd255);
    for (int i = 0; i < 4; i++) feed(10'(i), 8'd255, '0);
`ifdef QMAC_SATURATE_EN
    checkOutput("sat_w16", 32'(output_result), vres(16'h7FFF));
    checkOutput("sat_w8", 32'(output_result8), 32'h17F);
`else
    checkOutput("wrap_w16", 32'(output_result), vres(16'hF804));
    checkOutput("wrap_w8", 32'(output_result8), 32'h104);
`endif
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
